// File: rtl/stage_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// master: fetch side (drives req/addr); slave: memory side (drives ready/rvalid/rdata).
interface stage_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/stage_fetch.sv
// stage_fetch: front pipeline stage feeding decode.
// Issues one outstanding sequential imem request at a time, buffers responses
// in a small FIFO, and flushes/refetches on a redirect from the mem stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (halt on misaligned redirect).
module stage_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    stage_fetch_if.master      imem,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               de_stall,
    output logic               de_valid,
    output logic [31:0]        de_insn,
    output logic [31:0]        de_pc,
    output logic               fe_misalign
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    fetch_entry_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic [31:0]        pc;
    logic [31:0]        inflight_pc;
    logic               outstanding;
    logic               discard;
    logic               halted;

    logic               accept;
    logic               resp;
    logic               push;
    logic               pop;

    // Request only with no response pending, room in the buffer and not halted.
    assign imem.req  = reset_n & ~outstanding & (count < DEPTH_C) & ~halted;
    assign imem.addr = pc;

    assign accept   = imem.req & imem.ready;
    assign resp     = imem.rvalid & outstanding;
    assign push     = resp & ~discard & ~redirect;
    assign pop      = de_valid & ~de_stall & ~redirect;

    assign de_valid = (count != '0);
    assign de_insn  = fifo_mem[rd_ptr].insn;
    assign de_pc    = fifo_mem[rd_ptr].pc;

    // Fetch control: PC, outstanding/discard tracking and FIFO pointers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // A request that is or becomes in flight must have its response dropped.
            if (accept || (outstanding && !imem.rvalid)) begin
                outstanding <= 1'b1;
                discard     <= 1'b1;
            end else begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
        end else begin
            if (accept) begin
                outstanding <= 1'b1;
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end else if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Instruction buffer storage written on push.
    // NOTE: the data array has no reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: inflight_pc, insn: imem.rdata};
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Halt on a misaligned redirect; any aligned redirect clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            halted <= 1'b0;
        end else if (redirect) begin
            halted <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    logic unused_redirect_low;
    assign halted              = 1'b0;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

    assign fe_misalign = halted;

endmodule

// File: tb/tb_stage_fetch.sv
// Directed self-checking bench for stage_fetch.
// Main DUT uses RESET_PC=0; a second instance with RESET_PC=FFFFFFF8 checks PC wrap.
module tb_stage_fetch;
    logic        clk;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        de_stall;
    logic        de_valid;
    logic [31:0] de_insn;
    logic [31:0] de_pc;
    logic        fe_misalign;

    logic        w_valid;
    logic [31:0] w_insn;
    logic [31:0] w_pc;
    logic        w_misalign;

    logic        mem_ready;
    int          mem_lat;
    logic        extra_rvalid;
    logic        m_p1, m_p2;
    logic [31:0] m_a1, m_a2;
    logic        w_p1;
    logic [31:0] w_a1;

    int n_cmp;
    int n_bad;

    stage_fetch_if bus ();
    stage_fetch_if bus_w ();

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    stage_fetch u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .de_stall    (de_stall),
        .de_valid    (de_valid),
        .de_insn     (de_insn),
        .de_pc       (de_pc),
        .fe_misalign (fe_misalign)
    );

    stage_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (bus_w),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .de_stall    (1'b0),
        .de_valid    (w_valid),
        .de_insn     (w_insn),
        .de_pc       (w_pc),
        .fe_misalign (w_misalign)
    );

    // Memory model: responds 1 or 2 cycles after each acceptance.
    always @(posedge clk) begin
        m_p1 <= reset_n & bus.req & bus.ready;
        m_a1 <= bus.addr;
        m_p2 <= m_p1;
        m_a2 <= m_a1;
        w_p1 <= reset_n & bus_w.req & bus_w.ready;
        w_a1 <= bus_w.addr;
    end

    assign bus.ready    = mem_ready;
    assign bus.rvalid   = ((mem_lat == 2) ? m_p2 : m_p1) | extra_rvalid;
    assign bus.rdata    = insn_of((mem_lat == 2) ? m_a2 : m_a1);
    assign bus_w.ready  = 1'b1;
    assign bus_w.rvalid = w_p1;
    assign bus_w.rdata  = insn_of(w_a1);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_de(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, de_valid}, {31'b0, v});
        if (v) begin
            chk({tag, "_pc"}, de_pc, pc);
            chk({tag, "_insn"}, de_insn, insn_of(pc));
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] addr);
        chk({tag, "_req"}, {31'b0, bus.req}, {31'b0, r});
        if (r) chk({tag, "_addr"}, bus.addr, addr);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Holds reset for three edges, checks reset state, releases at a negedge (N0).
    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        de_stall     = 1'b0;
        extra_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, bus.req}, 32'd0);
        chk("rst_valid", {31'b0, de_valid}, 32'd0);
        chk("rst_misalign", {31'b0, fe_misalign}, 32'd0);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset_n      = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        de_stall     = 1'b0;
        extra_rvalid = 1'b0;
        mem_ready    = 1'b1;
        mem_lat      = 1;

        // Zero-wait memory: accept at N0->E1, rvalid in cycle 2, de_valid in cycle 3.
        do_reset();
        chk_req("seq_n0", 1'b1, 32'h0);
        step(); chk_de("seq_n1", 1'b0, 32'h0); chk_req("seq_n1", 1'b0, 32'h0);
        step(); chk_de("seq_n2", 1'b1, 32'h0); chk_req("seq_n2", 1'b1, 32'h4);
        chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        step(); chk_de("seq_n3", 1'b0, 32'h0);
        step(); chk_de("seq_n4", 1'b1, 32'h4);
        chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        step(); chk_de("seq_n5", 1'b0, 32'h0);
        step(); chk_de("seq_n6", 1'b1, 32'h8);
        chk("wrap_pc2", w_pc, 32'h0000_0000);
        chk("wrap_insn2", w_insn, insn_of(32'h0));

        // Stall five cycles: head holds at 0x8, 0xC fills the FIFO, requests stop.
        de_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_de("stall_hold", 1'b1, 32'h8);
            chk("stall_req", {31'b0, bus.req}, 32'd0);
        end
        de_stall = 1'b0;
        step(); chk_de("unstall_n12", 1'b1, 32'hC); chk_req("unstall_n12", 1'b1, 32'h10);
        step(); chk_de("unstall_n13", 1'b0, 32'h0);
        step(); chk_de("unstall_n14", 1'b1, 32'h10);

        // Two-cycle memory: redirect to 0x100 while 0x8 is in flight (no rvalid yet),
        // with decode stalled and 0x4 buffered.
        mem_lat = 2;
        do_reset();
        step(); chk_de("rd_n1", 1'b0, 32'h0);
        step(); chk_de("rd_n2", 1'b0, 32'h0);
        step(); chk_de("rd_n3", 1'b1, 32'h0); chk_req("rd_n3", 1'b1, 32'h4);
        step(); chk_de("rd_n4", 1'b0, 32'h0);
        step(); chk_de("rd_n5", 1'b0, 32'h0);
        step(); chk_de("rd_n6", 1'b1, 32'h4); chk_req("rd_n6", 1'b1, 32'h8);
        de_stall = 1'b1;
        step(); chk_de("rd_n7", 1'b1, 32'h4);
        redirect = 1'b1; redirect_pc = 32'h100;
        step(); redirect = 1'b0; de_stall = 1'b0;
        chk_de("rd_flush", 1'b0, 32'h0); chk_req("rd_discard", 1'b0, 32'h0);
        step(); chk_de("rd_n9", 1'b0, 32'h0); chk_req("rd_refetch", 1'b1, 32'h100);
        step(); chk_de("rd_n10", 1'b0, 32'h0);
        step(); chk_de("rd_n11", 1'b0, 32'h0);
        step(); chk_de("rd_first", 1'b1, 32'h100);

        // Zero-wait memory: redirect in the same cycle as rvalid.
        mem_lat = 1;
        do_reset();
        step(); redirect = 1'b1; redirect_pc = 32'h200;
        step(); redirect = 1'b0;
        chk_de("rv_n2", 1'b0, 32'h0); chk_req("rv_refetch", 1'b1, 32'h200);
        // Spurious rvalid with nothing outstanding must be ignored.
        extra_rvalid = 1'b1;
        step(); extra_rvalid = 1'b0;
        chk_de("spurious_ignored", 1'b0, 32'h0);
        step(); chk_de("rv_first", 1'b1, 32'h200); chk_req("rv_n4", 1'b1, 32'h204);
        // Redirect in the same cycle the 0x204 request is accepted.
        redirect = 1'b1; redirect_pc = 32'h300;
        step(); redirect = 1'b0;
        chk_de("acc_flush", 1'b0, 32'h0); chk_req("acc_discard", 1'b0, 32'h0);
        step(); chk_de("acc_n6", 1'b0, 32'h0); chk_req("acc_refetch", 1'b1, 32'h300);
        step(); chk_de("acc_n7", 1'b0, 32'h0);
        step(); chk_de("acc_first", 1'b1, 32'h300);

        // Misaligned redirect to 0x102, then aligned redirect to 0x200.
        mem_ready = 1'b0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h102;
        step(); redirect = 1'b0; mem_ready = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_flag", {31'b0, fe_misalign}, 32'd1);
        chk("mis_noreq", {31'b0, bus.req}, 32'd0);
        step();
        chk("mis_flag_hold", {31'b0, fe_misalign}, 32'd1);
        chk("mis_noreq_hold", {31'b0, bus.req}, 32'd0);
`else
        chk("mis_flag", {31'b0, fe_misalign}, 32'd0);
        chk_req("mis_forced", 1'b1, 32'h100);
        step();
        chk("mis_flag_hold", {31'b0, fe_misalign}, 32'd0);
`endif
        redirect = 1'b1; redirect_pc = 32'h200;
        step(); redirect = 1'b0;
        chk("mis_clear", {31'b0, fe_misalign}, 32'd0);
        chk_req("mis_resume", 1'b1, 32'h200);
        chk_de("mis_n3", 1'b0, 32'h0);
        step(); chk_de("mis_n4", 1'b0, 32'h0);
        step(); chk_de("mis_first", 1'b1, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
- Front pipeline stage, directly upstream of the decode stage.
- Generates sequential PCs and issues instruction-memory requests, one outstanding at a time.
- Buffers returned instructions in a small FIFO and presents de_valid/de_insn/de_pc to decode, honouring de_stall.
- Accepts a PC redirect from the mem stage (jump or taken branch), flushes buffered and in-flight instructions, and refetches from the new target.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- imem_req  out  1  request valid; address held stable until accepted
- imem_addr  out  32  word-aligned fetch address
- imem_ready  in  1  memory accepts request this cycle (imem_req & imem_ready)
- imem_rvalid  in  1  response valid; earliest one cycle after acceptance
- imem_rdata  in  32  instruction word
- redirect  in  1  mem stage redirect strobe
- redirect_pc  in  32  redirect target
- de_stall  in  1  decode cannot accept; hold outputs
- de_valid  out  1  de_insn/de_pc valid
- de_insn  out  32  instruction at FIFO head
- de_pc  out  32  PC of de_insn
- fe_misalign  out  1  misaligned redirect flagged (FETCH_ALIGN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset (clk edge with reset_n=0): pc=RESET_PC, FIFO empty, outstanding=0, discard=0, de_valid=0, imem_req=0, fe_misalign=0. An imem_rvalid arriving while outstanding=0 is ignored.
- imem_req = !outstanding & (count < FIFO_DEPTH) & !halted, combinational from registered state. imem_addr = pc.
- Accept (imem_req & imem_ready & !redirect): outstanding=1, pc=pc+4 with 32-bit wrap (FFFFFFFC -> 0). The accepted address is kept as inflight_pc.
- Response (imem_rvalid & outstanding & !discard & !redirect): push {inflight_pc, imem_rdata}, outstanding=0. Data becomes visible on de_* the next cycle. No same-cycle bypass. Latency from rvalid to de_valid is 1 cycle.
- de_valid = FIFO non-empty. de_insn/de_pc come from the head entry.
- Pop when de_valid & !de_stall. Push and pop may happen in the same cycle, and count is unchanged.
- While de_stall=1, de_* hold stable.
- A push is never issued when the FIFO is full, because the request was gated on room.
- Redirect takes priority over everything in the same cycle:
  - FIFO is flushed; de_valid=0 next cycle.
  - pc = redirect_pc, with bits [1:0] forced to 0.
  - If a request is accepted this same cycle, or outstanding=1 without rvalid this cycle: discard=1, outstanding=1.
  - If rvalid arrives this same cycle: the response is dropped and outstanding=0.
  - The redirect occurring while de_stall=1 does not matter; the flush still happens.
- Discarded response (rvalid & discard): dropped; outstanding=0, discard=0.
  - No new request is issued while discard=1; fetch resumes the cycle after.
- Back-to-back redirects: the last one wins. At most one discard is ever pending.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets halted=1 and fe_misalign=1 from the next cycle.
  - No requests are issued while halted; the FIFO is flushed as for a normal redirect.
  - A later aligned redirect clears halted and fe_misalign and resumes fetching.
  - Reset clears both.
- Undefined: low bits are silently forced to 0, halted is never set, and fe_misalign is tied 0.

Test Plan:
- Reset, then zero-wait memory (imem_ready=1, rvalid 1 cycle after accept) -> requests at 0,4,8,...; de_valid first rises 3 cycles after reset release; consecutive de_pc 0,4,8.
- de_stall=1 for 5 cycles while fetching -> FIFO fills to 2 and imem_req drops; de_insn/de_pc are unchanged during the stall. After release, pops proceed in order with no loss or duplication.
- Redirect to 0x100 while a request to 0x8 is in flight -> the 0x8 response is dropped and never appears on de_*. The next request is to 0x100, and de_pc=0x100 is the first valid output.
- Redirect in the same cycle as rvalid, and separately in the same cycle as acceptance -> neither response reaches decode; the refetch starts from the target.
- pc near wrap: RESET_PC=0xFFFFFFF8 -> de_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> fe_misalign=1, no imem_req. A subsequent redirect to 0x200 clears it and fetch resumes at 0x200. With the macro undefined, the same stimulus fetches from 0x100.
